ofm_writeback_ctrl: RTL and testbench

OFM_WRITEBACK_CTRL -- requirements
Module: ofm_writeback_ctrl

---
 rtl/ofm_writeback_ctrl_if.sv | 41 ++++
 rtl/ofm_writeback_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ofm_writeback_ctrl.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofm_writeback_ctrl_if.sv
// ---------------------------------------------------------------------------
// ofm_writeback_ctrl_if
// Bundles every non-clock/reset signal of the OFM write-back controller:
//   control   : start / ready / done / overflow, base_addr_OFM / size_OFM
//   producer  : word_written pulse
//   fused buf : rd_addr_fused / re_fused out, data_fused in (1-cycle latency)
//   global    : wr_addr_global / we_global / data_global out, global_stall in
// Modports:
//   master : the controller (drives the fused-buffer read and global write buses)
//   slave  : the environment around it (host, producer, memories)
// ---------------------------------------------------------------------------
interface ofm_writeback_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              ready;
    logic [31:0]       base_addr_OFM;
    logic [31:0]       size_OFM;
    logic              word_written;
    logic [31:0]       rd_addr_fused;
    logic              re_fused;
    logic [DATA_W-1:0] data_fused;
    logic [31:0]       wr_addr_global;
    logic              we_global;
    logic [DATA_W-1:0] data_global;
    logic              global_stall;
    logic              done;
    logic              overflow;

    modport master (
        input  start, base_addr_OFM, size_OFM, word_written, data_fused, global_stall,
        output ready, rd_addr_fused, re_fused, wr_addr_global, we_global, data_global,
               done, overflow
    );

    modport slave (
        output start, base_addr_OFM, size_OFM, word_written, data_fused, global_stall,
        input  ready, rd_addr_fused, re_fused, wr_addr_global, we_global, data_global,
               done, overflow
    );
endinterface

// File: rtl/ofm_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// ofm_writeback_ctrl
// Copies one OFM block from the fused buffer to global BRAM per start request.
// A pending counter tracks words committed by the producer but not yet read.
// Reads are issued into a 2-entry skid FIFO (counting words still in flight
// from the fused buffer), and the FIFO head is presented as the global write.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : ofm_writeback_ctrl_if.master (control, producer, fused-buffer
//              read bus, global BRAM write bus)
// Parameters:
//   DATA_W      : data word width
//   FUSED_DEPTH : fused-buffer depth in words (power of two)
// ---------------------------------------------------------------------------
module ofm_writeback_ctrl #(
    parameter int DATA_W      = 32,
    parameter int FUSED_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ofm_writeback_ctrl_if.master  bus
);
    localparam int AW = $clog2(FUSED_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(FUSED_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic [PW-1:0]     pending_q,  pending_d;
    logic              overflow_q, overflow_d;
    logic [AW-1:0]     rd_addr_q,  rd_addr_d;
    logic [31:0]       wr_addr_q,  wr_addr_d;
    logic [31:0]       size_q,     size_d;
    logic [31:0]       issued_q,   issued_d;
    logic [31:0]       accepted_q, accepted_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] fifo_mem_q [2];
    logic [DATA_W-1:0] fifo_mem_d [2];
    logic              fifo_wptr_q, fifo_wptr_d;
    logic              fifo_rptr_q, fifo_rptr_d;
    logic [1:0]        fifo_cnt_q,  fifo_cnt_d;

    logic start_acc;
    logic accept;
    logic re;
    logic [2:0] occupancy;

    always_comb begin
        start_acc = (state_q == ST_IDLE) && bus.start;
        accept    = (fifo_cnt_q != 2'd0) && !bus.global_stall;
        // Words buffered plus the one possibly returning from the fused buffer.
        occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
        // A read is allowed with a full skid path only if a pop frees a slot now.
        re = (state_q == ST_DRAIN) && (pending_q != '0) && (issued_q < size_q) &&
             ((occupancy < 3'd2) || accept);
    end

    // Pending counter and sticky overflow; counted regardless of state.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (bus.word_written && !re) begin
            if (pending_q == DEPTH_P) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PW'(1);
            end
        end else if (!bus.word_written && re) begin
            pending_d = pending_q - PW'(1);
        end
    end

    // Transfer bookkeeping.
    always_comb begin
        size_d     = size_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        wr_addr_d  = wr_addr_q;
        // Read pointer is free-running modulo the (power-of-two) depth.
        rd_addr_d  = re ? rd_addr_q + AW'(1) : rd_addr_q;
        inflight_d = re;
        if (start_acc) begin
            size_d     = bus.size_OFM;
            issued_d   = '0;
            accepted_d = '0;
            wr_addr_d  = bus.base_addr_OFM;
        end else begin
            if (re) begin
                issued_d = issued_q + 32'd1;
            end
            if (accept) begin
                accepted_d = accepted_q + 32'd1;
                wr_addr_d  = wr_addr_q + 32'd1;
            end
        end
    end

    // Skid FIFO: capture the word returned for last cycle's read; pop on accept.
    always_comb begin
        fifo_mem_d  = fifo_mem_q;
        fifo_wptr_d = fifo_wptr_q;
        fifo_rptr_d = fifo_rptr_q;
        if (inflight_q) begin
            fifo_mem_d[fifo_wptr_q] = bus.data_fused;
            fifo_wptr_d             = ~fifo_wptr_q;
        end
        if (accept) begin
            fifo_rptr_d = ~fifo_rptr_q;
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, accept};
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.size_OFM == 32'd0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Look at the count including this cycle's accept so done
                // follows the last accept by exactly one cycle.
                if ((accepted_q + {31'd0, accept}) == size_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            size_q      <= '0;
            issued_q    <= '0;
            accepted_q  <= '0;
            inflight_q  <= 1'b0;
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            size_q      <= size_d;
            issued_q    <= issued_d;
            accepted_q  <= accepted_d;
            inflight_q  <= inflight_d;
            fifo_wptr_q <= fifo_wptr_d;
            fifo_rptr_q <= fifo_rptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // FIFO storage is cleared on reset so data_global reads back as zero.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                fifo_mem_q[gi] <= '0;
            end else begin
                fifo_mem_q[gi] <= fifo_mem_d[gi];
            end
        end
    end

    assign bus.ready          = (state_q == ST_IDLE);
    assign bus.done           = (state_q == ST_DONE);
    assign bus.overflow       = overflow_q;
    assign bus.re_fused       = re;
    assign bus.rd_addr_fused  = {{(32-AW){1'b0}}, rd_addr_q};
    assign bus.wr_addr_global = wr_addr_q;
    assign bus.we_global      = (fifo_cnt_q != 2'd0);
    assign bus.data_global    = fifo_mem_q[fifo_rptr_q];
endmodule

// File: tb/tb_ofm_writeback_ctrl.sv
module tb_ofm_writeback_ctrl;
    localparam int D  = 16;
    localparam int DW = 32;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;

    ofm_writeback_ctrl_if #(.DATA_W(DW)) bus ();

    ofm_writeback_ctrl #(.DATA_W(DW), .FUSED_DEPTH(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [31:0] fdata(input int a);
        return 32'hC0DE_0000 + 32'(a) * 32'h0001_0101;
    endfunction

    // Fused-buffer model: data valid exactly one cycle after the read.
    initial begin
        bus.data_fused = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            if (bus.re_fused) bus.data_fused <= fdata(int'(bus.rd_addr_fused));
            else              bus.data_fused <= 32'hDEAD_BEEF;
        end
    end

    // Scoreboard and model state.
    logic [31:0] sb_addr [$];
    logic [31:0] sb_data [$];
    int          rd_q    [$];
    int          exp_rd_ptr;
    int          tb_pending;
    logic        exp_ovf;

    int n_reads, n_we, n_acc, stall_cycles, done_cnt, max_out;
    int first_re, first_we, last_acc, done_cyc;
    logic        prev_we, prev_stall;
    logic [31:0] prev_addr, prev_data;

    task automatic clear_stats();
        n_reads = 0; n_we = 0; n_acc = 0; stall_cycles = 0; done_cnt = 0; max_out = 0;
        first_re = -1; first_we = -1; last_acc = -1; done_cyc = -1;
    endtask

    // Monitor: compares every read address and accepted write against the scoreboard.
    initial begin
        logic [31:0] ea, ed;
        int er;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                tb_pending = 0; exp_ovf = 1'b0; prev_we = 1'b0; prev_stall = 1'b0;
            end else begin
                if (bus.re_fused) begin
                    n_reads++;
                    if (first_re < 0) first_re = cyc;
                    checks++;
                    if (rd_q.size() == 0) begin
                        errors++;
                        $display("FAIL rd_unexpected: read at addr %0d, required none", bus.rd_addr_fused);
                    end else begin
                        er = rd_q.pop_front();
                        if (bus.rd_addr_fused !== 32'(er)) begin
                            errors++;
                            $display("FAIL rd_addr: got %0d, required %0d", bus.rd_addr_fused, er);
                        end
                    end
                    checks++;
                    if (tb_pending == 0) begin
                        errors++;
                        $display("FAIL rd_no_pending: re_fused=1 with pending 0, required 0");
                    end
                end
                if (prev_we && prev_stall) begin
                    checks++;
                    if (bus.we_global !== 1'b1 || bus.wr_addr_global !== prev_addr ||
                        bus.data_global !== prev_data) begin
                        errors++;
                        $display("FAIL stall_hold: we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
                                 bus.we_global, bus.wr_addr_global, bus.data_global, prev_addr, prev_data);
                    end
                end
                if (bus.we_global) begin
                    n_we++;
                    if (first_we < 0) first_we = cyc;
                    if (bus.global_stall) begin
                        stall_cycles++;
                    end else begin
                        n_acc++;
                        last_acc = cyc;
                        checks++;
                        if (sb_addr.size() == 0) begin
                            errors++;
                            $display("FAIL wr_unexpected: write addr %h data %h, required none",
                                     bus.wr_addr_global, bus.data_global);
                        end else begin
                            ea = sb_addr.pop_front();
                            ed = sb_data.pop_front();
                            if (bus.wr_addr_global !== ea || bus.data_global !== ed) begin
                                errors++;
                                $display("FAIL wr_word: got addr %h data %h, required addr %h data %h",
                                         bus.wr_addr_global, bus.data_global, ea, ed);
                            end
                        end
                    end
                end
                if (n_reads - n_acc > max_out) max_out = n_reads - n_acc;
                if (bus.word_written && !bus.re_fused) begin
                    if (tb_pending == D) exp_ovf = 1'b1;
                    else                 tb_pending++;
                end else if (!bus.word_written && bus.re_fused) begin
                    tb_pending--;
                end
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_we    = bus.we_global;
                prev_stall = bus.global_stall;
                prev_addr  = bus.wr_addr_global;
                prev_data  = bus.data_global;
            end
        end
    end

    task automatic produce(input int n);
        @(posedge clk); #1;
        bus.word_written = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        bus.word_written = 1'b0;
    endtask

    task automatic launch(input logic [31:0] base, input int size, output int ts);
        for (int i = 0; i < size; i++) begin
            sb_addr.push_back(base + 32'(i));
            sb_data.push_back(fdata(exp_rd_ptr));
            rd_q.push_back(exp_rd_ptr);
            exp_rd_ptr = (exp_rd_ptr + 1) % D;
        end
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr_OFM = base; bus.size_OFM = 32'(size);
        ts = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_for_done(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles, required done", budget);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1 || bus.re_fused !== 1'b0 || bus.we_global !== 1'b0 ||
            bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b re=%b we=%b done=%b ovf=%b, required 1 0 0 0 0",
                     bus.ready, bus.re_fused, bus.we_global, bus.done, bus.overflow);
        end
        checks++;
        if (bus.rd_addr_fused !== 32'd0 || bus.wr_addr_global !== 32'd0 || bus.data_global !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: rd=%h wr=%h data=%h, required 0 0 0",
                     bus.rd_addr_fused, bus.wr_addr_global, bus.data_global);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        int ts;
        clear_stats();
        produce(8);
        launch(32'h100, 4, ts);
        wait_for_done(50);
        checks++;
        if (first_re != ts + 1) begin
            errors++; $display("FAIL basic_re_latency: got cycle %0d, required %0d", first_re, ts + 1);
        end
        checks++;
        if (first_we != ts + 3) begin
            errors++; $display("FAIL basic_we_latency: got cycle %0d, required %0d", first_we, ts + 3);
        end
        checks++;
        if (n_acc != 4 || last_acc - first_we != 3) begin
            errors++; $display("FAIL basic_burst: got %0d accepts over %0d cycles, required 4 over 4",
                               n_acc, last_acc - first_we + 1);
        end
        checks++;
        if (done_cyc != last_acc + 1) begin
            errors++; $display("FAIL basic_done_cycle: got %0d, required %0d", done_cyc, last_acc + 1);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.ready !== 1'b1 || done_cnt != 1) begin
            errors++; $display("FAIL basic_ready: ready=%b done pulses=%0d, required 1 and 1", bus.ready, done_cnt);
        end
        checks++;
        if (dut.pending_q !== 5'd4 || sb_addr.size() != 0) begin
            errors++; $display("FAIL basic_pending: pending=%0d left=%0d, required 4 and 0",
                               dut.pending_q, sb_addr.size());
        end
        $display("test_basic: base=0x100 size=4 accepts=%0d", n_acc);
    endtask

    task automatic test_stall();
        int ts, k;
        clear_stats();
        produce(4);
        launch(32'h200, 6, ts);
        k = 0;
        while (n_acc < 2 && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (n_acc < 2) begin
            errors++; $display("FAIL stall_wait: got %0d accepts, required 2", n_acc);
        end
        @(posedge clk); #1;
        bus.global_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.global_stall = 1'b0;
        wait_for_done(50);
        checks++;
        if (n_acc != 6 || sb_addr.size() != 0) begin
            errors++; $display("FAIL stall_count: got %0d accepts %0d left, required 6 and 0", n_acc, sb_addr.size());
        end
        checks++;
        if (stall_cycles != 3) begin
            errors++; $display("FAIL stall_cycles: got %0d, required 3", stall_cycles);
        end
        checks++;
        if (max_out > 2) begin
            errors++; $display("FAIL stall_outstanding: got %0d, required <=2", max_out);
        end
        $display("test_stall: size=6 accepts=%0d stalled=%0d", n_acc, stall_cycles);
    endtask

    task automatic test_trickle();
        int ts;
        clear_stats();
        launch(32'h300, 2, ts);
        wait_for_done(30);
        clear_stats();
        launch(32'h400, 5, ts);
        fork
            begin
                repeat (5) begin
                    @(posedge clk); #1; bus.word_written = 1'b1;
                    @(posedge clk); #1; bus.word_written = 1'b0;
                    @(posedge clk);
                end
            end
            wait_for_done(100);
        join
        checks++;
        if (n_acc != 5 || n_reads != 5 || sb_addr.size() != 0) begin
            errors++; $display("FAIL trickle_count: reads=%0d accepts=%0d, required 5 and 5", n_reads, n_acc);
        end
        checks++;
        if (dut.pending_q !== 5'd0) begin
            errors++; $display("FAIL trickle_pending: got %0d, required 0", dut.pending_q);
        end
        $display("test_trickle: size=5 reads=%0d accepts=%0d", n_reads, n_acc);
    endtask

    task automatic test_wrap();
        int ts;
        clear_stats();
        produce(13);
        launch(32'h500, 13, ts);
        wait_for_done(60);
        checks++;
        if (bus.rd_addr_fused !== 32'(D - 2)) begin
            errors++; $display("FAIL wrap_start: rd_addr=%0d, required %0d", bus.rd_addr_fused, D - 2);
        end
        clear_stats();
        produce(4);
        launch(32'h600, 4, ts);
        wait_for_done(40);
        checks++;
        if (n_acc != 4 || bus.rd_addr_fused !== 32'd2 || rd_q.size() != 0) begin
            errors++; $display("FAIL wrap_end: accepts=%0d rd_addr=%0d, required 4 and 2", n_acc, bus.rd_addr_fused);
        end
        $display("test_wrap: reads=%0d end rd_addr=%0d", n_reads, bus.rd_addr_fused);
    endtask

    task automatic test_zero_size();
        int ts;
        clear_stats();
        launch(32'h700, 0, ts);
        wait_for_done(10);
        checks++;
        if (done_cyc != ts + 1 || bus.ready !== 1'b0) begin
            errors++; $display("FAIL zero_done: done cycle %0d ready=%b, required %0d and 0", done_cyc, bus.ready, ts + 1);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.ready !== 1'b1 || n_reads != 0 || n_we != 0 || done_cnt != 1) begin
            errors++; $display("FAIL zero_idle: ready=%b reads=%0d writes=%0d done=%0d, required 1 0 0 1",
                               bus.ready, n_reads, n_we, done_cnt);
        end
        $display("test_zero_size: done_cycle=%0d", done_cyc - ts);
    endtask

    task automatic test_overflow();
        produce(D);
        checks++;
        if (bus.overflow !== 1'b0 || dut.pending_q !== 5'(D)) begin
            errors++; $display("FAIL ovf_full: ovf=%b pending=%0d, required 0 and %0d", bus.overflow, dut.pending_q, D);
        end
        produce(1);
        checks++;
        if (bus.overflow !== exp_ovf || bus.overflow !== 1'b1 || dut.pending_q !== 5'(D)) begin
            errors++; $display("FAIL ovf_set: ovf=%b pending=%0d, required 1 and %0d", bus.overflow, dut.pending_q, D);
        end
        $display("test_overflow: overflow=%b", bus.overflow);
    endtask

    task automatic test_reset_mid();
        int ts;
        clear_stats();
        bus.global_stall = 1'b1;
        launch(32'h800, 8, ts);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus.we_global !== 1'b1 || dut.fifo_cnt_q !== 2'd2) begin
            errors++; $display("FAIL mid_buffered: we=%b fifo=%0d, required 1 and 2", bus.we_global, dut.fifo_cnt_q);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.we_global !== 1'b0 || bus.re_fused !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.data_global !== 32'd0 || bus.wr_addr_global !== 32'd0 ||
            bus.rd_addr_fused !== 32'd0) begin
            errors++; $display("FAIL mid_reset: we=%b re=%b ready=%b done=%b ovf=%b data=%h wr=%h rd=%h, required reset values",
                               bus.we_global, bus.re_fused, bus.ready, bus.done, bus.overflow,
                               bus.data_global, bus.wr_addr_global, bus.rd_addr_fused);
        end
        sb_addr.delete(); sb_data.delete(); rd_q.delete();
        exp_rd_ptr = 0;
        repeat (2) @(posedge clk);
        #1;
        bus.global_stall = 1'b0;
        reset_n = 1'b1;
        clear_stats();
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (n_we != 0 || n_reads != 0) begin
            errors++; $display("FAIL mid_quiet: writes=%0d reads=%0d, required 0 and 0", n_we, n_reads);
        end
        produce(3);
        launch(32'h900, 3, ts);
        wait_for_done(30);
        checks++;
        if (n_acc != 3 || sb_addr.size() != 0) begin
            errors++; $display("FAIL mid_recover: accepts=%0d, required 3", n_acc);
        end
        $display("test_reset_mid: recovery accepts=%0d", n_acc);
    endtask

    initial begin
        checks = 0; errors = 0;
        exp_rd_ptr = 0; tb_pending = 0; exp_ovf = 1'b0;
        prev_we = 1'b0; prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
        bus.start = 1'b0; bus.base_addr_OFM = '0; bus.size_OFM = '0;
        bus.word_written = 1'b0; bus.global_stall = 1'b0;
        clear_stats();
        test_reset();
        test_basic();
        test_stall();
        test_trickle();
        test_wrap();
        test_zero_size();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end
endmodule
